// File: rtl/tl_async_a_source_pkg.sv
// Shared definitions for the TileLink A-channel async crossing source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tl_async_a_source_pkg;

    localparam int OPCODE_W    = 3;
    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 32;
    localparam int SYNC_STAGES = 3;

    // One A-channel beat as held in the crossing memory. param, size,
    // source, mask and corrupt are constants rebuilt on the sink side.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
    } a_entry_t;

endpackage

// File: rtl/tl_async_a_source_if.sv
// Bundle of the enqueue handshake and the async crossing wires.
// Latency: n/a (wires only).
// Backpressure: enq_valid/enq_ready handshake; crossing side is index based.
// Ports: master = source block view, slave = upstream producer + sink view.
interface tl_async_a_source_if;
    import tl_async_a_source_pkg::*;

    // Enqueue side
    logic                enq_valid;
    logic                enq_ready;
    logic [OPCODE_W-1:0] enq_bits_opcode;
    logic [ADDR_W-1:0]   enq_bits_address;
    logic [DATA_W-1:0]   enq_bits_data;

    // Single-entry crossing memory
    logic [OPCODE_W-1:0] async_mem_0_opcode;
    logic [ADDR_W-1:0]   async_mem_0_address;
    logic [DATA_W-1:0]   async_mem_0_data;

    // Indices and liveness/reset indications
    logic                async_widx;
    logic                async_ridx;
    logic                async_safe_widx_valid;
    logic                async_safe_ridx_valid;
    logic                async_safe_source_reset_n;
    logic                async_safe_sink_reset_n;

    modport master (
        input  enq_valid,
        output enq_ready,
        input  enq_bits_opcode,
        input  enq_bits_address,
        input  enq_bits_data,
        output async_mem_0_opcode,
        output async_mem_0_address,
        output async_mem_0_data,
        output async_widx,
        input  async_ridx,
        output async_safe_widx_valid,
        input  async_safe_ridx_valid,
        output async_safe_source_reset_n,
        input  async_safe_sink_reset_n
    );

    modport slave (
        output enq_valid,
        input  enq_ready,
        output enq_bits_opcode,
        output enq_bits_address,
        output enq_bits_data,
        input  async_mem_0_opcode,
        input  async_mem_0_address,
        input  async_mem_0_data,
        input  async_widx,
        output async_ridx,
        input  async_safe_widx_valid,
        output async_safe_ridx_valid,
        input  async_safe_source_reset_n,
        output async_safe_sink_reset_n
    );

endinterface

// File: rtl/tl_async_a_source_sync_3flop.sv
// Multi-flop synchronizer with synchronous clear, parameterized width.
// Latency: SYNC_STAGES clock edges from d to q.
// Backpressure: none; samples every cycle.
// Ports: clock, clr (sync clear), d (async input), q (synced), q_pre (one stage earlier).
module sync_3flop
    import tl_async_a_source_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_pre
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else begin
            stage_d[0] = d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        stage_q <= stage_d;
    end

    assign q     = stage_q[SYNC_STAGES-1];
    // The value q will take at the next edge; lets the owner act on a
    // falling input in the same cycle that q itself drops.
    assign q_pre = stage_q[SYNC_STAGES-2];

endmodule

// File: rtl/tl_async_a_source.sv
// Source half of a one-entry TileLink A-channel async crossing.
// Latency: accepted beat visible on async_mem_0_* and async_widx one cycle after fire.
// Backpressure: enq_ready low while the entry is full or the sink is not alive.
// Ports: clock, reset (sync, active-high), bus (tl_async_a_source_if.master).
module tl_async_a_source
    import tl_async_a_source_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    tl_async_a_source_if.master    bus
);

    // Synchronized sink state
    logic     ridx_s;
    logic     ridx_pre;
    logic     unused_ridx_pre;
    logic     sink_ok;
    logic     sink_ok_nxt;
    logic     sink_alive_in;
    logic     ridx_clr;

    // Source state
    logic     widx_q;
    logic     widx_d;
    a_entry_t mem_q;
    a_entry_t mem_d;
    logic     widx_valid_q;
    logic     widx_valid_d;

    a_entry_t enq_entry;
    logic     enq_ready;
    logic     fire;

    // Sink liveness: both its valid flag and its reset must say "up".
    assign sink_alive_in = bus.async_safe_ridx_valid & bus.async_safe_sink_reset_n;

    // The read index is held at zero whenever the sink is (about to be)
    // considered dead, so a returning sink always starts from index 0.
    assign ridx_clr = reset | ~sink_ok_nxt;

    sync_3flop #(.WIDTH(1)) u_sync_ridx (
        .clock (clock),
        .clr   (ridx_clr),
        .d     (bus.async_ridx),
        .q     (ridx_s),
        .q_pre (ridx_pre)
    );

    sync_3flop #(.WIDTH(1)) u_sync_ridx_valid (
        .clock (clock),
        .clr   (reset),
        .d     (sink_alive_in),
        .q     (sink_ok),
        .q_pre (sink_ok_nxt)
    );

    assign unused_ridx_pre = ridx_pre;

    // One-entry queue: a single index bit is both binary and Gray.
    assign enq_ready = sink_ok & (widx_q == ridx_s);
    assign fire      = bus.enq_valid & enq_ready;

    assign enq_entry = '{opcode:  bus.enq_bits_opcode,
                         address: bus.enq_bits_address,
                         data:    bus.enq_bits_data};

    always_comb begin
        widx_d       = widx_q;
        mem_d        = mem_q;
        widx_valid_d = 1'b1;

        if (fire) begin
            mem_d = enq_entry;
        end

        // Losing the sink wins over a simultaneous fire: the index
        // returns to zero and that beat is abandoned.
        if (!sink_ok_nxt) begin
            widx_d = 1'b0;
        end else if (fire) begin
            widx_d = ~widx_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            widx_q       <= 1'b0;
            mem_q        <= '0;
            widx_valid_q <= 1'b0;
        end else begin
            widx_q       <= widx_d;
            mem_q        <= mem_d;
            widx_valid_q <= widx_valid_d;
        end
    end

    assign bus.enq_ready                 = enq_ready;
    assign bus.async_mem_0_opcode        = mem_q.opcode;
    assign bus.async_mem_0_address       = mem_q.address;
    assign bus.async_mem_0_data          = mem_q.data;
    assign bus.async_widx                = widx_q;
    assign bus.async_safe_widx_valid     = widx_valid_q;
    assign bus.async_safe_source_reset_n = ~reset;

endmodule
